// File: rtl/ss_rr_arbiter.sv
// Packet-aware round-robin arbiter that merges NUM_INPUTS valid/ready/data/last streams into one
// registered output. Define SS_ARB_PKT_COUNT_EN to add per-input saturating packet counters.
module ss_rr_arbiter #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [IDX_W-1:0]                 out_src,
  output logic                             busy
`ifdef SS_ARB_PKT_COUNT_EN
  ,
  output logic [NUM_INPUTS*16-1:0]         pkt_count
`endif
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        gnt_q;
  logic [IDX_W-1:0]        ptr_q;

  logic [IDX_W-1:0]        win_idx;
  logic                    any_valid;
  logic                    out_space;
  logic                    accept;
  logic                    gnt_last;
  logic [DATA_WIDTH-1:0]   gnt_data;

  // Rotating first-set search starting at ptr_q.
  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] idx;
    win_idx   = '0;
    any_valid = 1'b0;
    j         = 0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
      idx = IDX_W'(j);
      if (!any_valid && in_valid[idx]) begin
        any_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign out_space = !out_valid || out_ready;
  assign gnt_last  = in_last[gnt_q];
  assign gnt_data  = in_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = (state_q == StLocked) && in_valid[gnt_q] && out_space;
  assign busy      = (state_q == StLocked);

  always_comb begin
    in_ready = '0;
    if (state_q == StLocked) in_ready[gnt_q] = out_space;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            gnt_q   <= win_idx;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (accept && gnt_last) begin
            state_q <= StIdle;
            ptr_q   <= (gnt_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : gnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A load wins over a drain, so a simultaneous load+drain keeps out_valid high.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_last  <= gnt_last;
        out_src   <= gnt_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SS_ARB_PKT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (accept && gnt_last && (pkt_count[gnt_q*16 +: 16] != 16'hFFFF)) begin
      pkt_count[gnt_q*16 +: 16] <= pkt_count[gnt_q*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ss_rr_arbiter.sv
// Self-checking bench for ss_rr_arbiter: per-cycle vector tables plus a beat scoreboard.
module tb_ss_rr_arbiter;

  localparam int unsigned NI = 4;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst;
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_ready;
  logic [NI*DW-1:0]  in_data;
  logic [NI-1:0]     in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [1:0]        out_src;
  logic              busy;
`ifdef SS_ARB_PKT_COUNT_EN
  logic [NI*16-1:0]  pkt_count;
`endif

  ss_rr_arbiter #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .busy      (busy)
`ifdef SS_ARB_PKT_COUNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    src;
  } exp_t;

  typedef struct packed {
    logic       ordy;
    logic       busy;
    logic       ovalid;
    logic [1:0] src;
  } vec_t;

  beat_t       src_q [NI][$];
  exp_t        exp_q [$];
  vec_t        vecs [19];
  logic [NI-1:0] en;
  logic [NI-1:0] hs;
  int          checks;
  int          failures;

  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [1:0]    prev_src;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Source models and output monitor: drive at negedge, sample 1 time unit later.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    hs = '0;
    for (int i = 0; i < NI; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        in_valid[i]           = 1'b1;
        in_data[i*DW +: DW]   = src_q[i][0].data;
        in_last[i]            = src_q[i][0].last;
      end else begin
        in_valid[i]           = 1'b0;
        in_data[i*DW +: DW]   = '0;
        in_last[i]            = 1'b0;
      end
    end
    #1;
    if (!rst) begin
      hs = in_valid & in_ready;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last_src", {30'd0, out_last, out_src[0]} | (32'(out_src) << 4),
            {30'd0, prev_last, prev_src[0]} | (32'(prev_src) << 4));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got data=%0h src=%0d, expected no beat", out_data, out_src);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (out_data !== e.data || out_last !== e.last || out_src !== e.src) begin
            failures++;
            $display("FAIL sb_beat: got data=%0h last=%0b src=%0d, expected data=%0h last=%0b src=%0d",
                     out_data, out_last, out_src, e.data, e.last, e.src);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_src   = out_src;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  task automatic check_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) src_q[i].delete();
    exp_q.delete();
    en = '1;
    step();
    sample();
    check_reset();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic push_pkt(input int src, input int len, input int id);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < len; k++) begin
      b.data = {8'(src), 8'(id), 16'(k)};
      b.last = (k == len - 1);
      src_q[src].push_back(b);
      e.data = b.data;
      e.last = b.last;
      e.src  = 2'(src);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      sample();
      if (exp_q.size() == 0 && !busy && !out_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
    end
    step();
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      out_ready = vecs[r].ordy;
      sample();
      chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(vecs[r].busy));
      chk($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(vecs[r].ovalid));
      if (vecs[r].ovalid) chk($sformatf("vec%0d_out_src", r), 32'(out_src), 32'(vecs[r].src));
      step();
    end
  endtask

  initial begin
    logic [3:0] rdy_pat;
    logic       timed_out;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    out_ready = 1'b1;
    en       = '1;
    hs       = '0;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    prev_stall = 1'b0;
    rdy_pat  = 4'b1001;

    // {out_ready, busy, out_valid, out_src}
    // Rows 0-5: 3-beat packet from input 2.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'd2};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd2};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd0};
    // Rows 6-18: all inputs with 1-beat packets, grant order 0,1,2,3,0,1.
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd2};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 2'd3};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 2'd0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 2'd1};

    step();
    do_reset();

    // 3-beat packet from input 2.
    push_pkt(2, 3, 0);
    run_table(0, 5);
    drain("t1");

    // Round robin across all inputs.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NI; s++) push_pkt(s, 1, p);
    run_table(6, 18);
    drain("t2");

    // Input 1 requests while input 0 is mid-packet; input 0 also drops valid mid-packet.
    do_reset();
    push_pkt(0, 4, 0);
    step();
    step();
    push_pkt(1, 2, 0);
    en[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("t3_busy_hold", 32'(busy), 32'd1);
      step();
    end
    en[0] = 1'b1;
    drain("t3");

    // Output backpressure during a 5-beat packet from input 3.
    do_reset();
    push_pkt(3, 5, 0);
    for (int c = 0; c < 20; c++) begin
      out_ready = rdy_pat[c % 4];
      step();
    end
    out_ready = 1'b1;
    drain("t4");

    // Reset mid-packet with a stalled beat held in the output register.
    do_reset();
    push_pkt(2, 1, 0);
    drain("t5a");
    push_pkt(1, 4, 1);
    timed_out = 1'b1;
    for (int c = 0; c < 50 && timed_out; c++) begin
      sample();
      if (exp_q.size() <= 2) timed_out = 1'b0;
      step();
    end
    chk("t5_two_beats_out", 32'(timed_out), 32'd0);
    out_ready = 1'b0;
    step();
    step();
    do_reset();
    push_pkt(0, 1, 2);
    push_pkt(3, 1, 2);
    drain("t5b");

`ifdef SS_ARB_PKT_COUNT_EN
    do_reset();
    push_pkt(1, 2, 0);
    push_pkt(3, 1, 0);
    push_pkt(1, 1, 1);
    push_pkt(1, 3, 2);
    drain("t6");
    sample();
    chk("pkt_count0", 32'(pkt_count[0 +: 16]), 32'd0);
    chk("pkt_count1", 32'(pkt_count[16 +: 16]), 32'd3);
    chk("pkt_count2", 32'(pkt_count[32 +: 16]), 32'd0);
    chk("pkt_count3", 32'(pkt_count[48 +: 16]), 32'd1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ss_rr_arbiter.md
Name: ss_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one simple-stream (valid/ready/data/last) output between NUM_INPUTS stream requesters.
- Once a requester is granted, the grant holds until that packet's last beat is accepted, so packets are never interleaved.
- The output is registered, one beat deep, so the block can feed a register-slice chain or a shared downstream engine directly.

Parameters:
- NUM_INPUTS, 4, number of requesting streams, 2..16
- DATA_WIDTH, 32, width of each data beat
- IDX_W, $clog2(NUM_INPUTS), width of the grant index (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic is on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_INPUTS  per-input beat valid
- in_ready  out  NUM_INPUTS  per-input beat accept
- in_data  in  NUM_INPUTS*DATA_WIDTH  packed beats; input i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  NUM_INPUTS  per-input end-of-packet flag
- out_valid  out  1  registered output valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  registered output beat
- out_last  out  1  registered end-of-packet flag
- out_src  out  IDX_W  index of the input that produced the current output beat
- busy  out  1  high while a grant is held (state LOCKED)

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, in_ready=0.
  - State=IDLE; priority pointer ptr=0, so input 0 has highest priority after reset.
- A beat transfers on a port when valid && ready on the same rising edge.
- State IDLE:
  - in_ready all 0.
  - If any in_valid is set, select the first set bit searching ptr, ptr+1, ... NUM_INPUTS-1, 0, ... ptr-1 (wrap-around).
  - Register the winner in gnt and move to LOCKED the next cycle.
  - Arbitration uses in_valid only; in_last is ignored in IDLE.
- State LOCKED:
  - in_ready[gnt] = (!out_valid || out_ready); all other in_ready are 0.
  - On a transfer from input gnt: out_data<=in_data[gnt], out_last<=in_last[gnt], out_src<=gnt, out_valid<=1.
  - If that beat has in_last=1: go to IDLE and set ptr<=gnt+1, wrapping to 0 at NUM_INPUTS.
- Output register:
  - If out_valid && out_ready and no new beat is loaded, out_valid<=0.
  - A load and a drain in the same cycle is a back-to-back pass; out_valid stays 1.
  - out_data, out_last and out_src hold their values while out_valid && !out_ready.
- Latency:
  - First beat of a packet appears on out_valid 2 cycles after its in_valid rises with the arbiter idle: 1 cycle grant, 1 cycle output register.
  - Steady-state throughput is 1 beat/cycle within a packet.
  - There is 1 idle arbitration cycle between packets.
- Boundary conditions:
  - Single-beat packet (valid && last on the first beat): LOCKED for exactly one transfer, then IDLE.
  - Granted input drops in_valid mid-packet: grant holds and no other input is served until its last beat.
  - Other inputs asserting valid while LOCKED are ignored until IDLE.
  - Only one requester active: it is re-granted after each packet, with 1 bubble cycle.
  - Output backpressure (out_ready=0): in_ready[gnt] deasserts once out_valid=1; no beat is lost or duplicated.
  - busy=1 exactly while state is LOCKED.
  - rst asserted mid-packet: next edge returns every reset value; the partial packet is abandoned, and any beat held in the output register is dropped.

Optional Feature:
- Macro SS_ARB_PKT_COUNT_EN.
- When defined, the block adds output port pkt_count, NUM_INPUTS*16 bits.
  - Input i's field is a 16-bit saturating counter, incremented when a beat with in_last=1 is accepted from input i.
  - It sticks at 16'hFFFF and is cleared to 0 by rst.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then input 2 sends a 3-beat packet (A0,A1,A2; last on A2) with out_ready=1 -> out_valid rises 2 cycles after in_valid; out_data A0,A1,A2 on consecutive cycles; out_src=2; out_last only on A2; busy=1 for 3 cycles.
- All 4 inputs hold 1-beat packets continuously from reset -> grant order 0,1,2,3,0,1; one bubble cycle between packets.
- Input 0 is mid-packet (beat 1 of 4) and input 1 asserts valid -> no input-1 beat appears until input 0's last beat is output; then out_src=1.
- out_ready toggled 1,0,0,1,... during a 5-beat packet from input 3 -> all 5 beats appear in order, no drops or duplicates, output stable while stalled.
- rst pulsed for 1 cycle after beat 2 of a 4-beat packet from input 1 -> all outputs return to reset values; input 0 then wins first, since ptr=0.
- With SS_ARB_PKT_COUNT_EN defined: 3 packets on input 1 and 1 packet on input 3 -> pkt_count fields read 0,3,0,1.
